pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Parametrised pipeline controller for the pipelined successor of the single-cycle MIPS core. It tracks per-stage valid/destination tags for an N-stage in-order pipeline, detects load-use hazards, generates forwarding selects for the execute stage, and applies branch flushes and external freezes. It drives the stage-register enables and PC enable; the datapath stage registers and muxes sit outside this block.

## Interface
Parameters:
- STAGES, 5, pipeline depth; stage 0 = fetch, 1 = decode, 2 = execute, STAGES-1 = writeback; legal 4..8
- RAW, 5, register address width
- BR_STAGE, 2, stage in which branch_taken is resolved; legal 2..STAGES-2
- LOAD_READY, 4, first stage from which a load result is forwardable; legal 3..STAGES-1
- SW, clog2(STAGES), width of forwarding selects

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-low
- fetch_valid  in  1  IF delivers a valid instruction this cycle
- id_rs, id_rt  in  RAW  source registers of the instruction in decode
- id_use_rs, id_use_rt  in  1  corresponding source is read
- id_rd  in  RAW  destination of the decode instruction
- id_wr  in  1  decode instruction writes id_rd
- id_load  in  1  decode instruction is a load
- branch_taken  in  1  instruction in BR_STAGE redirects the PC
- freeze  in  1  external hold (memory/peripheral busy)
- pc_en  out  1  PC register load enable
- stage_en  out  STAGES  per-stage register enable
- stage_valid  out  STAGES  per-stage valid bit
- lu_stall  out  1  load-use stall this cycle
- fwd_rs_sel, fwd_rt_sel  out  SW  execute-stage operand source: 0 = register file, k = result held in stage k
- stall_cnt, flush_cnt  out  16  saturating performance counters

## Operation
- Per-stage tags for s in 1..STAGES-1: valid, dest, wr, load. Stage 1 tags come from the id_* inputs; stages >=2 are internal and shift with the pipeline.
- Match(s, r): valid[s] && wr[s] && dest[s] == r && r != 0. Register 0 never matches.
- lu_stall = valid[1] && there exists s in 2..LOAD_READY-2 with load[s] && (Match(s, id_rs) && id_use_rs || Match(s, id_rt) && id_use_rt). This is combinational.
- Forwarding, captured when decode advances into stage 2: pick the youngest (lowest) s in 2..STAGES-2 that matches. The select is s+1. If nothing matches, the select is 0. A producer in STAGES-1 at decode writes the register file that cycle, so it yields 0 (register file is write-before-read).
- Cycle actions, in priority order:
  - freeze: all stage_en = 0, pc_en = 0, all state holds, branch_taken and lu_stall are ignored, counters hold. The branch source must hold branch_taken until it is unfrozen.
  - branch_taken: stages >= BR_STAGE advance (valid[s+1] <= valid[s]). valid[0..BR_STAGE] <= 0. pc_en = 1, loading the target. flush_cnt += 1. An lu_stall in the same cycle is overridden and stall_cnt does not increment.
  - lu_stall: stages 0 and 1 hold (stage_en[1:0] = 0, pc_en = 0). Stages >= 2 advance. Stage 2 receives a bubble (valid[2] <= 0, fwd selects <= 0). stall_cnt += 1.
  - otherwise: everything advances, valid[0] <= fetch_valid, pc_en = 1.
- stage_en[s] = 1 for every advancing stage, including bubble insertion.
- Counters saturate at 16'hFFFF.

## Timing
- Reset (reset == 0 at an edge): all valid = 0, tags = 0, fwd selects = 0, counters = 0.
- Combinational outputs under reset: pc_en = 1, stage_en = all 1s, lu_stall = 0.
- lu_stall, pc_en and stage_en are combinational from the current state and inputs, with zero latency. fwd selects and valid bits are registered, with 1-cycle latency.
- Reset mid-stall or mid-flush wins: the next cycle starts from an empty pipeline.
- A default load-use costs exactly 1 bubble. A branch at BR_STAGE = 2 costs 2 bubbles.
- Back-to-back branch_taken cycles are legal. Each one flushes and counts.

## Test plan
- Reset, then fetch_valid = 1 continuously with no hazards -> stage_valid fills 00001, 00011, 00111, 01111, 11111 over 5 cycles; pc_en stays 1.
- lw $8 followed by add $9,$8,$8 (defaults) -> lu_stall = 1 for exactly one cycle with pc_en = 0 and stage_en = 11100; next cycle fwd_rs_sel = fwd_rt_sel = 4 with the add in stage 2; stall_cnt = 1.
- add $8 followed by sub $10,$8,$8 -> no stall; fwd selects = 3. With one independent instruction between them -> selects = 4. With two between -> 0.
- Producer writes $0, consumer reads $0 -> no stall; fwd selects = 0.
- branch_taken in a cycle where lu_stall would also fire -> valid[0..2] cleared, pc_en = 1, flush_cnt = 1, stall_cnt unchanged.
- freeze held for 3 cycles with branch_taken asserted -> stage_valid and counters unchanged for 3 cycles; on release the flush is applied once.

Source files
------------

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl
//  Purpose  : Pipeline controller for an N-stage in-order MIPS pipeline.
//             Tracks per-stage valid/destination tags, detects load-use
//             hazards, produces execute-stage forwarding selects, and applies
//             branch flushes and external freezes. Drives stage-register
//             enables and the PC enable.
//  Ports    :
//    clk            in   clock, all state on rising edge
//    reset          in   synchronous, active-low
//    i_fetch_valid  in   IF delivers a valid instruction
//    i_id_rs/rt     in   decode source registers (RAW bits)
//    i_id_use_rs/rt in   corresponding source is read
//    i_id_rd        in   decode destination register
//    i_id_wr        in   decode instruction writes i_id_rd
//    i_id_load      in   decode instruction is a load
//    i_branch_taken in   instruction in BR_STAGE redirects the PC
//    i_freeze       in   external hold
//    o_pc_en        out  PC load enable (combinational)
//    o_stage_en     out  per-stage register enable (combinational)
//    o_stage_valid  out  per-stage valid bit (registered)
//    o_lu_stall     out  load-use stall (combinational)
//    o_fwd_rs/rt_sel out execute operand source, 0 = regfile, k = stage k
//    o_stall_cnt    out  saturating load-use stall counter
//    o_flush_cnt    out  saturating branch flush counter
//  Revision : 1.0  initial release
// ============================================================================
module pipe_ctrl #(
  parameter int STAGES     = 5,
  parameter int RAW        = 5,
  parameter int BR_STAGE   = 2,
  parameter int LOAD_READY = 4,
  parameter int SW         = $clog2(STAGES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_fetch_valid,
  input  logic [RAW-1:0]    i_id_rs,
  input  logic [RAW-1:0]    i_id_rt,
  input  logic              i_id_use_rs,
  input  logic              i_id_use_rt,
  input  logic [RAW-1:0]    i_id_rd,
  input  logic              i_id_wr,
  input  logic              i_id_load,
  input  logic              i_branch_taken,
  input  logic              i_freeze,
  output logic              o_pc_en,
  output logic [STAGES-1:0] o_stage_en,
  output logic [STAGES-1:0] o_stage_valid,
  output logic              o_lu_stall,
  output logic [SW-1:0]     o_fwd_rs_sel,
  output logic [SW-1:0]     o_fwd_rt_sel,
  output logic [15:0]       o_stall_cnt,
  output logic [15:0]       o_flush_cnt
);

  // Stage 1 tags are the live i_id_* inputs; only stages 2..STAGES-2 need
  // stored tags because the writeback stage never forwards.
  logic [STAGES-1:0] r_valid;
  logic [STAGES-2:2] r_wr;
  logic [STAGES-2:2] r_load;
  logic [RAW-1:0]    r_dest [2:STAGES-2];
  logic [SW-1:0]     r_fwd_rs;
  logic [SW-1:0]     r_fwd_rt;
  logic [15:0]       r_stall_cnt;
  logic [15:0]       r_flush_cnt;

  logic [STAGES-2:2] w_m_rs;
  logic [STAGES-2:2] w_m_rt;
  logic [STAGES-2:2] w_ld_hit;
  logic              w_rs_nz;
  logic              w_rt_nz;
  logic              w_lu_stall;
  logic [SW-1:0]     w_fwd_rs;
  logic [SW-1:0]     w_fwd_rt;

  assign w_rs_nz = |i_id_rs;
  assign w_rt_nz = |i_id_rt;

  for (genvar s = 2; s <= STAGES-2; s++) begin : g_match
    assign w_m_rs[s] = r_valid[s] & r_wr[s] & (r_dest[s] == i_id_rs) & w_rs_nz;
    assign w_m_rt[s] = r_valid[s] & r_wr[s] & (r_dest[s] == i_id_rt) & w_rt_nz;
    // Only loads still short of LOAD_READY force a stall.
    assign w_ld_hit[s] = (s <= LOAD_READY-2) & r_load[s] &
                         ((w_m_rs[s] & i_id_use_rs) | (w_m_rt[s] & i_id_use_rt));
  end

  assign w_lu_stall = r_valid[1] & (|w_ld_hit);

  // The producer moves one stage further while the consumer enters execute,
  // hence s+1. Scanning oldest-to-youngest lets the youngest match win.
  always_comb begin
    w_fwd_rs = '0;
    w_fwd_rt = '0;
    for (int s = STAGES-2; s >= 2; s--) begin
      if (w_m_rs[s]) w_fwd_rs = SW'(s + 1);
      if (w_m_rt[s]) w_fwd_rt = SW'(s + 1);
    end
  end

  always_comb begin
    o_pc_en    = 1'b1;
    o_stage_en = '1;
    o_lu_stall = 1'b0;
    if (reset) begin
      o_lu_stall = w_lu_stall;
      if (i_freeze) begin
        o_pc_en    = 1'b0;
        o_stage_en = '0;
      end else if (i_branch_taken) begin
        o_pc_en    = 1'b1;
        o_stage_en = '1;
      end else if (w_lu_stall) begin
        o_pc_en    = 1'b0;
        o_stage_en = {{(STAGES-2){1'b1}}, 2'b00};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid     <= '0;
      r_wr        <= '0;
      r_load      <= '0;
      for (int s = 2; s <= STAGES-2; s++) r_dest[s] <= '0;
      r_fwd_rs    <= '0;
      r_fwd_rt    <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (!i_freeze) begin
      if (i_branch_taken) begin
        // Older stages drain normally; everything up to BR_STAGE is squashed.
        for (int s = BR_STAGE; s <= STAGES-3; s++) begin
          r_wr[s+1]   <= r_wr[s];
          r_load[s+1] <= r_load[s];
          r_dest[s+1] <= r_dest[s];
        end
        for (int s = BR_STAGE; s <= STAGES-2; s++) r_valid[s+1] <= r_valid[s];
        for (int s = 0; s <= BR_STAGE; s++) r_valid[s] <= 1'b0;
        r_fwd_rs    <= '0;
        r_fwd_rt    <= '0;
        r_flush_cnt <= (r_flush_cnt == 16'hFFFF) ? r_flush_cnt : r_flush_cnt + 16'd1;
      end else begin
        for (int s = 2; s <= STAGES-3; s++) begin
          r_wr[s+1]   <= r_wr[s];
          r_load[s+1] <= r_load[s];
          r_dest[s+1] <= r_dest[s];
        end
        for (int s = 2; s <= STAGES-2; s++) r_valid[s+1] <= r_valid[s];
        r_wr[2]   <= i_id_wr;
        r_load[2] <= i_id_load;
        r_dest[2] <= i_id_rd;
        if (w_lu_stall) begin
          r_valid[2]  <= 1'b0;
          r_fwd_rs    <= '0;
          r_fwd_rt    <= '0;
          r_stall_cnt <= (r_stall_cnt == 16'hFFFF) ? r_stall_cnt : r_stall_cnt + 16'd1;
        end else begin
          r_valid[2] <= r_valid[1];
          r_valid[1] <= r_valid[0];
          r_valid[0] <= i_fetch_valid;
          r_fwd_rs   <= r_valid[1] ? w_fwd_rs : '0;
          r_fwd_rt   <= r_valid[1] ? w_fwd_rt : '0;
        end
      end
    end
  end

  assign o_stage_valid = r_valid;
  assign o_fwd_rs_sel  = r_fwd_rs;
  assign o_fwd_rt_sel  = r_fwd_rt;
  assign o_stall_cnt   = r_stall_cnt;
  assign o_flush_cnt   = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_ctrl
//  Purpose  : Self-checking bench for pipe_ctrl with a stage-record model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_ctrl;
  localparam int STAGES     = 5;
  localparam int RAW        = 5;
  localparam int BR_STAGE   = 2;
  localparam int LOAD_READY = 4;
  localparam int SW         = $clog2(STAGES);

  logic              clk;
  logic              reset;
  logic              fetch_valid;
  logic [RAW-1:0]    id_rs, id_rt, id_rd;
  logic              id_use_rs, id_use_rt, id_wr, id_load;
  logic              branch_taken, freeze;
  logic              pc_en;
  logic [STAGES-1:0] stage_en, stage_valid;
  logic              lu_stall;
  logic [SW-1:0]     fwd_rs_sel, fwd_rt_sel;
  logic [15:0]       stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_ctrl #(
    .STAGES(STAGES), .RAW(RAW), .BR_STAGE(BR_STAGE),
    .LOAD_READY(LOAD_READY), .SW(SW)
  ) dut (
    .clk(clk), .reset(reset), .i_fetch_valid(fetch_valid),
    .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_use_rs(id_use_rs),
    .i_id_use_rt(id_use_rt), .i_id_rd(id_rd), .i_id_wr(id_wr),
    .i_id_load(id_load), .i_branch_taken(branch_taken), .i_freeze(freeze),
    .o_pc_en(pc_en), .o_stage_en(stage_en), .o_stage_valid(stage_valid),
    .o_lu_stall(lu_stall), .o_fwd_rs_sel(fwd_rs_sel), .o_fwd_rt_sel(fwd_rt_sel),
    .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: one record per stage describing the instruction it holds.
  bit             m_valid [STAGES];
  bit             m_wr    [STAGES];
  bit             m_load  [STAGES];
  logic [RAW-1:0] m_dest  [STAGES];
  int             m_fwd_rs, m_fwd_rt, m_stall, m_flush;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_match(int s, logic [RAW-1:0] r);
    return m_valid[s] && m_wr[s] && (m_dest[s] == r) && (r != 0);
  endfunction

  function automatic bit m_lu();
    if (!m_valid[1]) return 1'b0;
    for (int s = 2; s <= LOAD_READY-2; s++)
      if (m_load[s] && ((m_match(s, id_rs) && id_use_rs) || (m_match(s, id_rt) && id_use_rt)))
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_sel(logic [RAW-1:0] r);
    for (int s = 2; s <= STAGES-2; s++)
      if (m_match(s, r)) return s + 1;
    return 0;
  endfunction

  function automatic logic [STAGES-1:0] m_vec();
    logic [STAGES-1:0] v;
    for (int s = 0; s < STAGES; s++) v[s] = m_valid[s];
    return v;
  endfunction

  task automatic model_update();
    bit lu;
    int rs_s, rt_s;
    lu   = m_lu();
    rs_s = m_sel(id_rs);
    rt_s = m_sel(id_rt);
    if (!reset) begin
      for (int s = 0; s < STAGES; s++) begin
        m_valid[s] = 0; m_wr[s] = 0; m_load[s] = 0; m_dest[s] = '0;
      end
      m_fwd_rs = 0; m_fwd_rt = 0; m_stall = 0; m_flush = 0;
    end else if (!freeze && branch_taken) begin
      for (int s = STAGES-1; s > BR_STAGE; s--) begin
        m_valid[s] = m_valid[s-1]; m_wr[s] = m_wr[s-1];
        m_load[s] = m_load[s-1]; m_dest[s] = m_dest[s-1];
      end
      for (int s = 0; s <= BR_STAGE; s++) m_valid[s] = 0;
      m_fwd_rs = 0; m_fwd_rt = 0;
      if (m_flush < 65535) m_flush++;
    end else if (!freeze) begin
      for (int s = STAGES-1; s > 2; s--) begin
        m_valid[s] = m_valid[s-1]; m_wr[s] = m_wr[s-1];
        m_load[s] = m_load[s-1]; m_dest[s] = m_dest[s-1];
      end
      if (lu) begin
        m_valid[2] = 0; m_fwd_rs = 0; m_fwd_rt = 0;
        if (m_stall < 65535) m_stall++;
      end else begin
        m_fwd_rs = m_valid[1] ? rs_s : 0;
        m_fwd_rt = m_valid[1] ? rt_s : 0;
        m_valid[2] = m_valid[1]; m_wr[2] = id_wr; m_load[2] = id_load; m_dest[2] = id_rd;
        m_valid[1] = m_valid[0];
        m_valid[0] = fetch_valid;
      end
    end
  endtask

  // Compare every output against the model, then clock one edge.
  task automatic tick();
    logic              e_pc, e_lu;
    logic [STAGES-1:0] e_en;
    #1;
    e_lu = reset ? m_lu() : 1'b0;
    e_pc = 1'b1;
    e_en = '1;
    if (reset) begin
      if (freeze) begin e_pc = 1'b0; e_en = '0; end
      else if (!branch_taken && e_lu) begin e_pc = 1'b0; e_en = {{(STAGES-2){1'b1}}, 2'b00}; end
    end
    chk("m_valid", 32'(stage_valid), 32'(m_vec()));
    chk("m_fwd_rs", 32'(fwd_rs_sel), m_fwd_rs);
    chk("m_fwd_rt", 32'(fwd_rt_sel), m_fwd_rt);
    chk("m_stall_cnt", 32'(stall_cnt), m_stall);
    chk("m_flush_cnt", 32'(flush_cnt), m_flush);
    chk("m_pc_en", 32'(pc_en), 32'(e_pc));
    chk("m_stage_en", 32'(stage_en), 32'(e_en));
    chk("m_lu_stall", 32'(lu_stall), 32'(e_lu));
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_id(int rs, int rt, bit urs, bit urt, int rd, bit wr, bit ld);
    id_rs = RAW'(rs); id_rt = RAW'(rt); id_use_rs = urs; id_use_rt = urt;
    id_rd = RAW'(rd); id_wr = wr; id_load = ld;
  endtask

  task automatic do_reset();
    reset = 1'b0; freeze = 1'b0; branch_taken = 1'b0; fetch_valid = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b1;
  endtask

  task automatic fill(int n);
    set_id(0, 0, 0, 0, 0, 0, 0);
    repeat (n) tick();
  endtask

  initial begin
    reset = 1'b0; freeze = 1'b0; branch_taken = 1'b0; fetch_valid = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    model_update();
    #1;

    // Reset state and pipeline fill.
    do_reset();
    chk("rst_valid", 32'(stage_valid), 0);
    chk("rst_stall_cnt", 32'(stall_cnt), 0);
    chk("rst_flush_cnt", 32'(flush_cnt), 0);
    chk("rst_fwd", 32'({fwd_rs_sel, fwd_rt_sel}), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("fill_valid", 32'(stage_valid), (32'd1 << (i + 1)) - 1);
      chk("fill_pc_en", 32'(pc_en), 1);
    end

    // lw $8 ; add $9,$8,$8
    do_reset();
    fill(2);
    set_id(0, 0, 0, 0, 8, 1, 1); tick();
    set_id(8, 8, 1, 1, 9, 1, 0); #1;
    chk("lu_stall_on", 32'(lu_stall), 1);
    chk("lu_pc_en", 32'(pc_en), 0);
    chk("lu_stage_en", 32'(stage_en), 32'b11100);
    tick();
    #1;
    chk("lu_stall_off", 32'(lu_stall), 0);
    tick();
    chk("lu_fwd_rs", 32'(fwd_rs_sel), 4);
    chk("lu_fwd_rt", 32'(fwd_rt_sel), 4);
    chk("lu_stall_cnt", 32'(stall_cnt), 1);

    // ALU producer at distance 1, 2, 3.
    do_reset();
    fill(2);
    set_id(1, 2, 1, 1, 8, 1, 0); tick();
    set_id(8, 8, 1, 1, 10, 1, 0); #1;
    chk("alu_no_stall", 32'(lu_stall), 0);
    tick();
    chk("alu_d1_rs", 32'(fwd_rs_sel), 3);
    chk("alu_d1_rt", 32'(fwd_rt_sel), 3);
    set_id(1, 2, 1, 1, 8, 1, 0);  tick();
    set_id(1, 2, 1, 1, 20, 1, 0); tick();
    set_id(8, 8, 1, 1, 10, 1, 0); tick();
    chk("alu_d2_rs", 32'(fwd_rs_sel), 4);
    chk("alu_d2_rt", 32'(fwd_rt_sel), 4);
    set_id(1, 2, 1, 1, 8, 1, 0);  tick();
    set_id(1, 2, 1, 1, 20, 1, 0); tick();
    set_id(1, 2, 1, 1, 21, 1, 0); tick();
    set_id(8, 8, 1, 1, 10, 1, 0); tick();
    chk("alu_d3_rs", 32'(fwd_rs_sel), 0);
    chk("alu_d3_rt", 32'(fwd_rt_sel), 0);

    // $0 never matches, even for a load.
    do_reset();
    fill(2);
    set_id(0, 0, 0, 0, 0, 1, 1); tick();
    set_id(0, 0, 1, 1, 5, 1, 0); #1;
    chk("r0_no_stall", 32'(lu_stall), 0);
    tick();
    chk("r0_fwd", 32'({fwd_rs_sel, fwd_rt_sel}), 0);
    chk("r0_stall_cnt", 32'(stall_cnt), 0);

    // Branch overrides a simultaneous load-use stall.
    do_reset();
    fill(2);
    set_id(0, 0, 0, 0, 8, 1, 1); tick();
    set_id(8, 8, 1, 1, 9, 1, 0);
    branch_taken = 1'b1; #1;
    chk("br_pc_en", 32'(pc_en), 1);
    chk("br_stage_en", 32'(stage_en), 32'b11111);
    tick();
    branch_taken = 1'b0;
    chk("br_valid", 32'(stage_valid), 32'b01000);
    chk("br_flush_cnt", 32'(flush_cnt), 1);
    chk("br_stall_cnt", 32'(stall_cnt), 0);

    // Freeze holds a pending branch for 3 cycles.
    do_reset();
    fill(3);
    set_id(0, 0, 0, 0, 0, 0, 0);
    freeze = 1'b1; branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("frz_pc_en", 32'(pc_en), 0);
      tick();
      chk("frz_valid", 32'(stage_valid), 32'b00111);
      chk("frz_flush_cnt", 32'(flush_cnt), 0);
    end
    freeze = 1'b0;
    tick();
    branch_taken = 1'b0;
    chk("unfrz_flush_cnt", 32'(flush_cnt), 1);
    chk("unfrz_valid", 32'(stage_valid), 32'b01000);
    tick();
    chk("unfrz_flush_once", 32'(flush_cnt), 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      reset        = ($urandom_range(63) != 0);
      freeze       = ($urandom_range(7) == 0);
      branch_taken = ($urandom_range(7) == 0);
      fetch_valid  = ($urandom_range(4) != 0);
      set_id($urandom_range(3), $urandom_range(3), 1'($urandom), 1'($urandom),
             $urandom_range(3), 1'($urandom), ($urandom_range(2) == 0));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
